pre_if_fetch: RTL and testbench
===============================

# pre_if_fetch

Pre-IF fetch unit in the 5-stage LoongArch pipeline, sitting directly upstream of the IF stage. Owns the fetch PC and drives the instruction memory over an SRAM-like request/response bus (req/addr_ok/data_ok), so that variable memory latency is decoupled from the pipeline. Delivers one {adef, pc, inst} packet at a time to IF under a valid/allowin handshake. Applies exception, ertn and branch redirects, and discards responses to cancelled fetches.

## Interface
- RESET_PC, 32'h1c000000, first fetch address after reset
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- if_allowin  in  1  IF can accept a packet this cycle
- pif_if_valid  out  1  packet on pif_if_bus is valid
- pif_if_bus  out  65  {adef, pc[31:0], inst[31:0]}
- id_if_bus  in  33  {br_taken, br_target[31:0]}
- wb_ex  in  1  exception flush; ex_entry  in  32  exception target
- ertn_flush  in  1  ertn flush; ertn_entry  in  32  ertn target
- inst_sram_req  out  1; inst_sram_wr  out  1 (always 0); inst_sram_size  out  2 (always 2'b10)
- inst_sram_addr  out  32; inst_sram_wstrb  out  4 (0); inst_sram_wdata  out  32 (0)
- inst_sram_addr_ok  in  1; inst_sram_data_ok  in  1; inst_sram_rdata  in  32

## Operation
- redirect = wb_ex | ertn_flush | br_taken; target priority: ex_entry > ertn_entry > br_target.
- States: IDLE, REQ, WAIT, CANCEL, HOLD. At most one outstanding memory request at any time.
- IDLE: entered only on reset. Moves to REQ on the next cycle.
- REQ: if pc[1:0] != 0, no request is issued; latch adef=1, inst=0, then go to HOLD. Otherwise inst_sram_req=1 and addr=pc, both held stable until addr_ok. On req&addr_ok, go to WAIT.
- WAIT: on data_ok, latch rdata into the buffer with adef=0, then go to HOLD.
- HOLD: pif_if_valid=1. On if_allowin: pc <= pc+4, go to REQ.
- Redirect handling (pc <= target in every case):
  - IDLE, REQ without addr_ok, or HOLD: go to REQ. Any buffered packet is dropped.
  - REQ with addr_ok in the same cycle: go to CANCEL.
  - WAIT without data_ok: go to CANCEL.
  - WAIT with data_ok in the same cycle: data is dropped; go to REQ.
  - CANCEL: stay in CANCEL with the new pc.
- CANCEL: req=0. On data_ok, the data is dropped; go to REQ.
- pif_if_valid = (HOLD) & ~redirect, so the output is masked in the same cycle as a redirect.
- pc arithmetic is 32-bit modulo; 0xfffffffc+4 wraps to 0.

## Timing
- Reset: state=IDLE, pc=RESET_PC. pif_if_valid=0, inst_sram_req=0, pif_if_bus=0.
- First req is asserted 2 cycles after resetn deasserts (IDLE, then REQ).
- Zero-wait memory (addr_ok in the req cycle, data_ok the next cycle): pif_if_valid rises 1 cycle after data_ok. Throughput is 1 inst per 3 cycles without bypass.
- Redirect is sampled every cycle; its effect on req/addr is visible the next cycle.
- Reset asserted mid-operation: immediate return to reset values. Any outstanding response after reset is the memory's responsibility and is not tracked.

## Configuration
- PRE_IF_BYPASS_EN defined:
  - In WAIT, data_ok & if_allowin & ~redirect drives pif_if_valid=1 in the same cycle, with pif_if_bus = {0, pc, rdata}.
  - pc advances and the state goes directly to REQ, skipping HOLD.
  - Zero-wait throughput becomes 1 inst per 2 cycles.
- Undefined: every response passes through the HOLD buffer.

## Test plan
- Reset release, zero-wait memory, if_allowin=1: req with addr 0x1c000000, then 0x1c000004. Packets arrive in order with inst equal to the memory contents, and no duplicates.
- if_allowin=0 for 5 cycles while in HOLD: pif_if_valid stays 1, the bus is stable, no new req is issued, and pc stays put.
- br_taken to 0x1c000100 during WAIT with 3-cycle data_ok latency: the stale data is dropped and never becomes valid. The next req has addr 0x1c000100.
- wb_ex and br_taken asserted in the same cycle: ex_entry is chosen. pif_if_valid is 0 in that cycle.
- ertn_entry=0x1c000102: no req is issued. The packet has adef=1, pc=0x1c000102, inst=0.
- With PRE_IF_BYPASS_EN, zero-wait memory: pif_if_valid is asserted in the data_ok cycle, and a new req follows the next cycle.

Source files
------------

// File: rtl/pre_if_fetch.sv
// Pre-IF fetch unit: owns the fetch PC, issues one instruction-SRAM request at a time and hands {adef, pc, inst} to IF.
// Optional macro PRE_IF_BYPASS_EN forwards read data to IF in its arrival cycle instead of buffering it first.
module pre_if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        if_allowin,
    output logic        pif_if_valid,
    output logic [64:0] pif_if_bus,
    input  logic [32:0] id_if_bus,
    input  logic        wb_ex,
    input  logic [31:0] ex_entry,
    input  logic        ertn_flush,
    input  logic [31:0] ertn_entry,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [31:0] inst_sram_addr,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CANCEL,
        S_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        adef_q, adef_d;

    logic        br_taken;
    logic [31:0] br_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        pc_aligned;
    logic [31:0] pc_seq;

    assign br_taken    = id_if_bus[32];
    assign br_target   = id_if_bus[31:0];
    assign redirect    = wb_ex | ertn_flush | br_taken;
    assign redirect_pc = wb_ex ? ex_entry : (ertn_flush ? ertn_entry : br_target);
    assign pc_aligned  = (pc_q[1:0] == 2'b00);
    assign pc_seq      = pc_q + 32'd4;

    // Read-only port: the write side of the bus is tied off.
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_wdata = 32'h0;
    assign inst_sram_addr  = pc_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inst_d        = inst_q;
        adef_d        = adef_q;
        inst_sram_req = 1'b0;
        pif_if_valid  = 1'b0;
        pif_if_bus    = '0;

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (!pc_aligned) begin
                    adef_d  = 1'b1;
                    inst_d  = 32'h0;
                    state_d = S_HOLD;
                end else begin
                    inst_sram_req = 1'b1;
                    if (inst_sram_addr_ok) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (inst_sram_data_ok) begin
                    inst_d  = inst_sram_rdata;
                    adef_d  = 1'b0;
                    state_d = S_HOLD;
`ifdef PRE_IF_BYPASS_EN
                    if (if_allowin && !redirect) begin
                        pif_if_valid = 1'b1;
                        pif_if_bus   = {1'b0, pc_q, inst_sram_rdata};
                        pc_d         = pc_seq;
                        state_d      = S_REQ;
                    end
`endif
                end
            end
            S_CANCEL: begin
                if (inst_sram_data_ok) state_d = S_REQ;
            end
            S_HOLD: begin
                pif_if_valid = ~redirect;
                pif_if_bus   = {adef_q, pc_q, inst_q};
                if (if_allowin) begin
                    pc_d    = pc_seq;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A redirect overrides everything above; an accepted request must still drain its response.
        if (redirect) begin
            pc_d = redirect_pc;
            case (state_q)
                S_REQ:    state_d = (pc_aligned && inst_sram_addr_ok) ? S_CANCEL : S_REQ;
                S_WAIT:   state_d = inst_sram_data_ok ? S_REQ : S_CANCEL;
                S_CANCEL: state_d = inst_sram_data_ok ? S_REQ : S_CANCEL;
                default:  state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            adef_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            adef_q  <= adef_d;
        end
    end

endmodule

// File: tb/tb_pre_if_fetch.sv
// Self-checking bench for pre_if_fetch: directed scenarios plus randomized redirects and memory latency,
// checked every cycle against a PC-stream model of what IF must receive.
module tb_pre_if_fetch;

    logic        clk = 1'b0;
    logic        resetn;
    logic        if_allowin;
    logic        pif_if_valid;
    logic [64:0] pif_if_bus;
    logic [32:0] id_if_bus;
    logic        wb_ex;
    logic [31:0] ex_entry;
    logic        ertn_flush;
    logic [31:0] ertn_entry;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    pre_if_fetch dut (
        .clk               (clk),
        .resetn            (resetn),
        .if_allowin        (if_allowin),
        .pif_if_valid      (pif_if_valid),
        .pif_if_bus        (pif_if_bus),
        .id_if_bus         (id_if_bus),
        .wb_ex             (wb_ex),
        .ex_entry          (ex_entry),
        .ertn_flush        (ertn_flush),
        .ertn_entry        (ertn_entry),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    always #5 clk = ~clk;

    // Stimulus knobs applied at the next step
    logic        s_rstn = 1'b0;
    logic        s_allow = 1'b1;
    logic        s_ex = 1'b0, s_ertn = 1'b0, s_br = 1'b0;
    logic [31:0] s_ex_t = '0, s_ertn_t = '0, s_br_t = '0;
    int          fixed_lat = 1;
    logic        addr_rand = 1'b0;

    // Memory model
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;

    // Reference model: the PC IF must see next, and whether its packet is already on offer
    logic [31:0] exp_pc = 32'h1c000000;
    logic        have_pkt = 1'b0;
    int          idle_cnt = 0;
    int          n_deliv = 0;
    int          n_req_seen = 0;
    int          n_valid_seen = 0;
    int          n_pass = 0;
    int          n_total = 0;

    function automatic logic [64:0] exp_bus(input logic [31:0] pc);
        logic adef;
        adef = (pc[1:0] != 2'b00);
        return {adef, pc, adef ? 32'h0 : ~pc};
    endfunction

    task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        logic        redir;
        logic [31:0] tgt;
        int          lat;
        @(negedge clk);
        resetn     = s_rstn;
        if_allowin = s_allow;
        wb_ex      = s_ex;
        ex_entry   = s_ex_t;
        ertn_flush = s_ertn;
        ertn_entry = s_ertn_t;
        id_if_bus  = {s_br, s_br_t};
        inst_sram_data_ok = mem_busy && (mem_cnt == 0);
        inst_sram_rdata   = inst_sram_data_ok ? ~mem_addr : $urandom();
        inst_sram_addr_ok = !mem_busy && inst_sram_req && (!addr_rand || ($urandom_range(0, 1) == 1));
        #1;
        if (!s_rstn) begin
            check("reset_outputs", {pif_if_valid, inst_sram_req, pif_if_bus}, '0);
            exp_pc = 32'h1c000000; have_pkt = 1'b0; mem_busy = 1'b0; mem_cnt = 0; idle_cnt = 0;
            return;
        end
        redir = s_ex | s_ertn | s_br;
        tgt   = s_ex ? s_ex_t : (s_ertn ? s_ertn_t : s_br_t);
        if (inst_sram_req) n_req_seen++;
        if (pif_if_valid) n_valid_seen++;

        check("bus_tieoffs", {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata},
              {1'b0, 2'b10, 4'b0000, 32'h0});
        if (inst_sram_req) begin
            check("one_outstanding", mem_busy, 1'b0);
            check("req_addr", inst_sram_addr, exp_pc);
        end
        if (exp_pc[1:0] != 2'b00 || have_pkt) check("no_req", inst_sram_req, 1'b0);
        if (redir) check("valid_masked", pif_if_valid, 1'b0);
        else if (have_pkt) check("hold_valid", pif_if_valid, 1'b1);
        if (pif_if_valid) check("pkt", pif_if_bus, exp_bus(exp_pc));

        if (redir) begin
            exp_pc = tgt; have_pkt = 1'b0; idle_cnt = 0;
        end else if (pif_if_valid && s_allow) begin
            $display("pkt pc=%h inst=%h adef=%0d", pif_if_bus[63:32], pif_if_bus[31:0], pif_if_bus[64]);
            exp_pc = exp_pc + 32'd4; have_pkt = 1'b0; idle_cnt = 0; n_deliv++;
        end else begin
            if (pif_if_valid) have_pkt = 1'b1;
            idle_cnt++;
        end
        if (idle_cnt > 80) begin
            check("watchdog_progress", idle_cnt, 0);
            idle_cnt = 0;
        end

        if (inst_sram_addr_ok) begin
            lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 4);
            mem_busy = 1'b1; mem_addr = inst_sram_addr; mem_cnt = lat - 1;
        end else if (inst_sram_data_ok) begin
            mem_busy = 1'b0;
        end else if (mem_busy && mem_cnt > 0) begin
            mem_cnt--;
        end
    endtask

    task automatic wait_valid(input string nm);
        for (int k = 0; k < 40; k++) begin
            step();
            if (pif_if_valid) break;
        end
        check(nm, pif_if_valid, 1'b1);
    endtask

    task automatic wait_req(input string nm);
        for (int k = 0; k < 40; k++) begin
            step();
            if (inst_sram_req) break;
        end
        check(nm, inst_sram_req, 1'b1);
    endtask

    initial begin
        resetn = 1'b0; if_allowin = 1'b0; id_if_bus = '0; wb_ex = 1'b0; ex_entry = '0;
        ertn_flush = 1'b0; ertn_entry = '0; inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0;
        inst_sram_rdata = '0;
        repeat (3) step();

        // Reset release with zero-wait memory
        s_rstn = 1'b1;
        step();
        check("idle_no_req", inst_sram_req, 1'b0);
        step();
        check("first_req", {inst_sram_req, inst_sram_addr}, {1'b1, 32'h1c000000});
        step();
`ifdef PRE_IF_BYPASS_EN
        check("bypass_pkt", {pif_if_valid, inst_sram_data_ok, pif_if_bus},
              {1'b1, 1'b1, 65'h0_1c000000_e3ffffff});
        step();
`else
        check("wait_no_valid", {pif_if_valid, inst_sram_data_ok}, {1'b0, 1'b1});
        step();
        check("first_pkt", {pif_if_valid, pif_if_bus}, {1'b1, 65'h0_1c000000_e3ffffff});
        step();
`endif
        check("second_req", {inst_sram_req, inst_sram_addr}, {1'b1, 32'h1c000004});

        // IF stalls for 5 cycles while a packet is held
        s_allow = 1'b0;
        wait_valid("stall_arrive");
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_hold", {pif_if_valid, inst_sram_req, pif_if_bus},
                  {1'b1, 1'b0, 65'h0_1c000004_e3fffffb});
        end
        s_allow = 1'b1;
        step();
        check("stall_accept", pif_if_valid, 1'b1);
        fixed_lat = 3;
        wait_req("third_req_seen");
        check("third_req", inst_sram_addr, 32'h1c000008);

        // Branch while the fetch is waiting on slow data
        s_br = 1'b1; s_br_t = 32'h1c000100;
        n_valid_seen = 0;
        step();
        s_br = 1'b0;
        fixed_lat = 1;
        wait_req("br_req_seen");
        check("br_req_addr", inst_sram_addr, 32'h1c000100);
        check("br_stale_dropped", n_valid_seen, 0);

        // Exception and branch together: exception target wins
        s_allow = 1'b0;
        wait_valid("ex_hold");
        s_ex = 1'b1; s_ex_t = 32'h1c000200; s_br = 1'b1; s_br_t = 32'h1c000300;
        step();
        check("ex_br_valid", pif_if_valid, 1'b0);
        s_ex = 1'b0; s_br = 1'b0;
        wait_req("ex_req_seen");
        check("ex_req_addr", inst_sram_addr, 32'h1c000200);

        // ertn to a misaligned entry: adef packet without a memory request
        s_ertn = 1'b1; s_ertn_t = 32'h1c000102;
        step();
        s_ertn = 1'b0;
        n_req_seen = 0;
        wait_valid("adef_seen");
        check("adef_pkt", pif_if_bus, 65'h1_1c000102_00000000);
        check("adef_no_req", n_req_seen, 0);

        // PC wrap-around
        s_ertn = 1'b1; s_ertn_t = 32'hfffffffc;
        step();
        s_ertn = 1'b0;
        wait_valid("wrap_seen");
        check("wrap_pkt", pif_if_bus, 65'h0_fffffffc_00000003);
        s_allow = 1'b1;
        step();
        wait_req("wrap_req_seen");
        check("wrap_req_addr", inst_sram_addr, 32'h0);

        // Randomized traffic
        addr_rand = 1'b1; fixed_lat = 0; n_deliv = 0;
        for (int k = 0; k < 2500; k++) begin
            s_allow = ($urandom_range(0, 3) != 0);
            s_ex = 1'b0; s_ertn = 1'b0; s_br = 1'b0;
            if ($urandom_range(0, 99) < 6) begin
                s_ex   = ($urandom_range(0, 2) == 0);
                s_ertn = ($urandom_range(0, 2) == 0);
                s_br   = !(s_ex || s_ertn) || ($urandom_range(0, 1) == 1);
                s_ex_t   = $urandom() & ~32'h3;
                s_ertn_t = $urandom() & ~32'h3;
                s_br_t   = $urandom() & ~32'h3;
                if ($urandom_range(0, 7) == 0) s_br_t[1:0] = 2'($urandom_range(1, 3));
            end
            step();
        end
        s_ex = 1'b0; s_ertn = 1'b0; s_br = 1'b0;
        check("random_delivered", (n_deliv > 100), 1'b1);

        // Reset in the middle of operation
        s_rstn = 1'b0;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
